rx_driver: RTL and testbench

RX_DRIVER -- requirements
Module: rx_driver

---
 rtl/rx_driver_pkg.sv | 19 +
 rtl/rx_timeout_counter.sv | 38 +++
 rtl/rx_driver.sv | 148 ++++++++++++++
 tb/tb_rx_driver.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/rx_driver_pkg.sv
// rtl/rx_driver_pkg.sv - shared state encoding and frame constants for rx_driver
package rx_driver_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_PAYLOAD = 2'b01,
        ST_CHECK   = 2'b10,
        ST_DONE    = 2'b11
    } rx_state_e;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;
    localparam int         PAYLOAD_LEN       = 3;

    // Frame checksum: XOR of the three payload bytes
    function automatic logic [7:0] payload_xor(input logic [23:0] p);
        return p[23:16] ^ p[15:8] ^ p[7:0];
    endfunction

endpackage

// File: rtl/rx_timeout_counter.sv
// rtl/rx_timeout_counter.sv - 16-bit inter-byte idle counter with expiry flag
module rx_timeout_counter #(
    parameter int TIMEOUT = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [15:0] LIMIT = 16'(TIMEOUT - 1);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    // Clear has priority so an accepted byte restarts the idle window
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == LIMIT);

endmodule

// File: rtl/rx_driver.sv
// rtl/rx_driver.sv - byte-stream frame decoder: sync, 3-byte payload, XOR checksum
module rx_driver
    import rx_driver_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = DEFAULT_SYNC_BYTE,
    parameter int         TIMEOUT   = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RxFull,
    input  logic [7:0]  RxData,
    output logic        RcvGo,
    output logic [1:0]  OutState,
    output logic [23:0] MsgData,
    output logic        MsgValid,
    output logic        ChkErr,
    output logic        TimeoutErr,
    output logic [7:0]  MsgCnt
);

    rx_state_e   state_q,       state_d;
    logic        rcv_go_q,      rcv_go_d;
    logic        blank_q,       blank_d;
    logic [1:0]  idx_q,         idx_d;
    logic [23:0] payload_q,     payload_d;
    logic        match_q,       match_d;
    logic [23:0] msg_data_q,    msg_data_d;
    logic        msg_valid_q,   msg_valid_d;
    logic        chk_err_q,     chk_err_d;
    logic        timeout_err_q, timeout_err_d;
    logic [7:0]  msg_cnt_q,     msg_cnt_d;

    logic in_frame;
    logic accept;
    logic expired;

    // The strobe cycle is blank: RxFull still shows the byte being consumed
    assign in_frame = (state_q == ST_PAYLOAD) || (state_q == ST_CHECK);
    assign accept   = (state_q != ST_DONE) && RxFull && !rcv_go_q && !blank_q;

    rx_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (accept || !in_frame),
        .enable  (in_frame),
        .expired (expired)
    );

    // Next-state and datapath; a byte accept on the expiry edge beats the timeout
    always_comb begin
        state_d       = state_q;
        rcv_go_d      = 1'b0;
        blank_d       = 1'b0;
        idx_d         = idx_q;
        payload_d     = payload_q;
        match_d       = match_q;
        msg_data_d    = msg_data_q;
        msg_valid_d   = 1'b0;
        chk_err_d     = 1'b0;
        timeout_err_d = 1'b0;
        msg_cnt_d     = msg_cnt_q;

        if (accept) begin
            rcv_go_d = 1'b1;
            blank_d  = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (accept && (RxData == SYNC_BYTE)) begin
                    state_d = ST_PAYLOAD;
                    idx_d   = 2'd0;
                end
            end
            ST_PAYLOAD: begin
                if (accept) begin
                    payload_d = {payload_q[15:0], RxData};
                    if (idx_q == 2'(PAYLOAD_LEN - 1)) begin
                        state_d = ST_CHECK;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end else if (expired) begin
                    timeout_err_d = 1'b1;
                    state_d       = ST_IDLE;
                end
            end
            ST_CHECK: begin
                if (accept) begin
                    match_d = (RxData == payload_xor(payload_q));
                    state_d = ST_DONE;
                end else if (expired) begin
                    timeout_err_d = 1'b1;
                    state_d       = ST_IDLE;
                end
            end
            ST_DONE: begin
                if (match_q) begin
                    msg_valid_d = 1'b1;
                    msg_data_d  = payload_q;
                    msg_cnt_d   = msg_cnt_q + 8'd1;
                end else begin
                    chk_err_d = 1'b1;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            rcv_go_q      <= 1'b0;
            blank_q       <= 1'b0;
            idx_q         <= 2'd0;
            payload_q     <= '0;
            match_q       <= 1'b0;
            msg_data_q    <= '0;
            msg_valid_q   <= 1'b0;
            chk_err_q     <= 1'b0;
            timeout_err_q <= 1'b0;
            msg_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            rcv_go_q      <= rcv_go_d;
            blank_q       <= blank_d;
            idx_q         <= idx_d;
            payload_q     <= payload_d;
            match_q       <= match_d;
            msg_data_q    <= msg_data_d;
            msg_valid_q   <= msg_valid_d;
            chk_err_q     <= chk_err_d;
            timeout_err_q <= timeout_err_d;
            msg_cnt_q     <= msg_cnt_d;
        end
    end

    assign RcvGo      = rcv_go_q;
    assign OutState   = state_q;
    assign MsgData    = msg_data_q;
    assign MsgValid   = msg_valid_q;
    assign ChkErr     = chk_err_q;
    assign TimeoutErr = timeout_err_q;
    assign MsgCnt     = msg_cnt_q;

endmodule

// File: tb/tb_rx_driver.sv
// tb/tb_rx_driver.sv - directed self-checking bench for rx_driver
module tb_rx_driver;

    logic        clk    = 1'b0;
    logic        rst    = 1'b0;
    logic        RxFull = 1'b0;
    logic [7:0]  RxData = 8'h00;
    logic        RcvGo;
    logic [1:0]  OutState;
    logic [23:0] MsgData;
    logic        MsgValid;
    logic        ChkErr;
    logic        TimeoutErr;
    logic [7:0]  MsgCnt;

    rx_driver #(.SYNC_BYTE(8'hA5), .TIMEOUT(1000)) dut (
        .clk        (clk),
        .rst        (rst),
        .RxFull     (RxFull),
        .RxData     (RxData),
        .RcvGo      (RcvGo),
        .OutState   (OutState),
        .MsgData    (MsgData),
        .MsgValid   (MsgValid),
        .ChkErr     (ChkErr),
        .TimeoutErr (TimeoutErr),
        .MsgCnt     (MsgCnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    int rcvgo_cnt = 0, valid_cnt = 0, chkerr_cnt = 0, toerr_cnt = 0;
    int excl_cnt = 0, data_bad = 0;
    int b_rcvgo, b_valid, b_chkerr, b_toerr;
    logic [23:0] prev_data = '0;
    logic [1:0]  last_st   = 2'b00;
    logic [1:0]  st_log[$];

    // Pulse counters and state-change log, sampled 2 time units after each rising edge
    always @(posedge clk) begin
        #2;
        if (RcvGo)      rcvgo_cnt++;
        if (MsgValid)   valid_cnt++;
        if (ChkErr)     chkerr_cnt++;
        if (TimeoutErr) toerr_cnt++;
        if (MsgValid && ChkErr) excl_cnt++;
        if (rst && (MsgData != prev_data) && !MsgValid) data_bad++;
        prev_data = MsgData;
        if (OutState != last_st) begin
            st_log.push_back(OutState);
            last_st = OutState;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic snap();
        b_rcvgo  = rcvgo_cnt;
        b_valid  = valid_cnt;
        b_chkerr = chkerr_cnt;
        b_toerr  = toerr_cnt;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Present one byte and drop RxFull on the strobe, like the receiver does
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        RxFull = 1'b1;
        RxData = b;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (RcvGo) break;
        end
        if (!RcvGo) check_eq("rcvgo_wait", {31'b0, RcvGo}, 32'd1);
        RxFull = 1'b0;
    endtask

    task automatic send_frame(input logic [39:0] f);
        for (int i = 4; i >= 0; i--) send_byte(f[i*8 +: 8]);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int lat, n, lastk, gap_bad;

        // reset state
        idle(3);
        check_eq("rst_state",   {30'b0, OutState}, 32'd0);
        check_eq("rst_rcvgo",   {31'b0, RcvGo},    32'd0);
        check_eq("rst_msgcnt",  {24'b0, MsgCnt},   32'd0);
        rst = 1'b1;
        @(negedge clk);
        check_eq("post_rst_data",  {8'b0, MsgData}, 32'd0);
        check_eq("post_rst_flags", {29'b0, MsgValid, ChkErr, TimeoutErr}, 32'd0);

        // good frame
        snap();
        st_log.delete();
        check_eq("t1_st_init", {30'b0, OutState}, 32'd0);
        send_frame(40'hA5_12_34_56_70);
        idle(4);
        check_eq("t1_rcvgo",  rcvgo_cnt - b_rcvgo, 5);
        check_eq("t1_valid",  valid_cnt - b_valid, 1);
        check_eq("t1_chkerr", chkerr_cnt - b_chkerr, 0);
        check_eq("t1_data",   {8'b0, MsgData}, 32'h123456);
        check_eq("t1_cnt",    {24'b0, MsgCnt}, 32'd1);
        check_eq("t1_st_len", st_log.size(), 4);
        for (int i = 0; i < 4; i++)
            check_eq($sformatf("t1_st%0d", i),
                     (i < st_log.size()) ? {30'b0, st_log[i]} : 32'hFFFF,
                     (i == 3) ? 32'd0 : i + 1);

        // bad checksum
        snap();
        send_frame(40'hA5_12_34_56_00);
        idle(4);
        check_eq("t2_chkerr", chkerr_cnt - b_chkerr, 1);
        check_eq("t2_valid",  valid_cnt - b_valid, 0);
        check_eq("t2_data",   {8'b0, MsgData}, 32'h123456);
        check_eq("t2_cnt",    {24'b0, MsgCnt}, 32'd1);

        // garbage then good frame
        snap();
        send_byte(8'h00);
        send_byte(8'hFF);
        check_eq("t3_idle", {30'b0, OutState}, 32'd0);
        send_frame(40'hA5_01_02_03_00);
        idle(4);
        check_eq("t3_rcvgo", rcvgo_cnt - b_rcvgo, 7);
        check_eq("t3_valid", valid_cnt - b_valid, 1);
        check_eq("t3_data",  {8'b0, MsgData}, 32'h010203);
        check_eq("t3_cnt",   {24'b0, MsgCnt}, 32'd2);

        // inter-byte timeout after A5,11
        snap();
        send_byte(8'hA5);
        send_byte(8'h11);
        lat = 0;
        for (int k = 1; k <= 1100; k++) begin
            @(negedge clk);
            if (TimeoutErr && lat == 0) lat = k;
        end
        check_eq("t4_latency", lat, 1000);
        check_eq("t4_toerr",   toerr_cnt - b_toerr, 1);
        check_eq("t4_state",   {30'b0, OutState}, 32'd0);
        send_frame(40'hA5_01_02_03_00);
        idle(4);
        check_eq("t4_valid",  valid_cnt - b_valid, 1);
        check_eq("t4_cnt",    {24'b0, MsgCnt}, 32'd3);
        check_eq("t4_toerr2", toerr_cnt - b_toerr, 1);

        // byte accepted on the very edge the counter expires
        snap();
        send_byte(8'hA5);
        idle(998);
        send_byte(8'h07);
        send_byte(8'h08);
        send_byte(8'h09);
        send_byte(8'h06);
        idle(4);
        check_eq("t5_toerr", toerr_cnt - b_toerr, 0);
        check_eq("t5_valid", valid_cnt - b_valid, 1);
        check_eq("t5_data",  {8'b0, MsgData}, 32'h070809);
        check_eq("t5_cnt",   {24'b0, MsgCnt}, 32'd4);

        // RxFull held high across A5 x5
        snap();
        n = 0; lastk = 0; gap_bad = 0;
        @(negedge clk);
        RxFull = 1'b1;
        RxData = 8'hA5;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (RcvGo) begin
                if (n > 0 && (k - lastk) != 2) gap_bad++;
                lastk = k;
                n++;
                if (n == 5) begin
                    RxFull = 1'b0;
                    break;
                end
            end
        end
        RxFull = 1'b0;
        idle(4);
        check_eq("t6_pulses", n, 5);
        check_eq("t6_gaps",   gap_bad, 0);
        check_eq("t6_valid",  valid_cnt - b_valid, 1);
        check_eq("t6_chkerr", chkerr_cnt - b_chkerr, 0);
        check_eq("t6_data",   {8'b0, MsgData}, 32'hA5A5A5);
        check_eq("t6_cnt",    {24'b0, MsgCnt}, 32'd5);

        // asynchronous reset mid-frame
        snap();
        send_byte(8'hA5);
        send_byte(8'h12);
        #3 rst = 1'b0;
        #1;
        check_eq("t7_rcvgo", {31'b0, RcvGo},    32'd0);
        check_eq("t7_state", {30'b0, OutState}, 32'd0);
        check_eq("t7_data",  {8'b0, MsgData},   32'd0);
        check_eq("t7_cnt",   {24'b0, MsgCnt},   32'd0);
        check_eq("t7_flags", {29'b0, MsgValid, ChkErr, TimeoutErr}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        snap();
        send_frame(40'hA5_12_34_56_70);
        idle(4);
        check_eq("t7_valid", valid_cnt - b_valid, 1);
        check_eq("t7_data2", {8'b0, MsgData}, 32'h123456);
        check_eq("t7_cnt2",  {24'b0, MsgCnt}, 32'd1);

        check_eq("excl_pulses",   excl_cnt, 0);
        check_eq("data_stable",   data_bad, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
